// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path.
// Holds the state encoding, the opcodes, the aluop codes (also used by the ALU
// decoder), the alusrcb/pcsrc select codes and the bundled control word
// produced by the state decoder.
package mips_ctrl_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore state-to-control decode for the multicycle MIPS controller.
// Ports: state_i (current state), mem_ready_i (memory handshake, qualifies
// the one-shot write strobes), ctrl_o (full control word).
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.pcsrc   = PCSRC_ALU;
        // IR and PC load only on the cycle the fetch actually completes.
        ctrl_o.irwrite = mem_ready_i;
        ctrl_o.pcwrite = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alusrcb = SRCB_IMMSH;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_req  = 1'b1;
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = mem_ready_i;
      end
      S_EXECUTE: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_B;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_B;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.pcsrc   = PCSRC_ALUOUT;
        ctrl_o.branch  = 1'b1;
      end
      S_ADDIWB: begin
        ctrl_o.regwrite = 1'b1;
      end
      S_JEX: begin
        ctrl_o.pcsrc   = PCSRC_JUMP;
        ctrl_o.pcwrite = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core.
// Ports: clk/reset (async active-low), op (IR opcode), zero (ALU flag),
// mem_ready (memory handshake); outputs are the datapath enables/selects,
// pcen, mem_req, the illegal_op / mem_timeout pulses and the debug state.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       pcen,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam logic [3:0] WMAX = 4'(MEM_WAIT_MAX);

  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;
  logic       tmo_q, tmo_d;
  ctrl_t      ctrl;

  mips_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Stall counter: counts unanswered memory-request cycles, saturating, and
  // restarts whenever the access completes or the FSM moves on.
  always_comb begin
    cnt_d = cnt_q;
    if (mem_ready || (state_d != state_q)) cnt_d = '0;
    else if (ctrl.mem_req && (cnt_q != WMAX)) cnt_d = cnt_q + 4'd1;
  end

  assign tmo_d     = (cnt_d == WMAX) && (cnt_q != WMAX);
  assign illegal_d = (state_q == S_DECODE) && !op_legal(op);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      tmo_q     <= tmo_d;
    end
  end

  assign mem_req     = ctrl.mem_req;
  assign memwrite    = ctrl.memwrite;
  assign irwrite     = ctrl.irwrite;
  assign regwrite    = ctrl.regwrite;
  assign iord        = ctrl.iord;
  assign regdst      = ctrl.regdst;
  assign memtoreg    = ctrl.memtoreg;
  assign alusrca     = ctrl.alusrca;
  assign alusrcb     = ctrl.alusrcb;
  assign pcsrc       = ctrl.pcsrc;
  assign aluop       = ctrl.aluop;
  assign pcen        = ctrl.pcwrite | (ctrl.branch & zero);
  assign illegal_op  = illegal_q;
  assign mem_timeout = tmo_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a table of whole instructions run
// with mem_ready tied high, plus hand sequences for reset, branch, memory
// stall and stall-timeout behaviour.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero, mem_ready;
  logic       mem_req, memwrite, irwrite, regwrite, iord, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       pcen, illegal_op, mem_timeout;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .pcen(pcen),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
  );

  // Per-step nibbles, step 0 leftmost. ctl nibble = {regwrite, memwrite, pcen, memtoreg}.
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        zero;
    int          len;
    logic [23:0] sts;
    logic [23:0] ctls;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic [5:0] o, input logic z, input int l,
                     input logic [23:0] s, input logic [23:0] c, input logic il);
    vec_t v;
    v.name = n; v.op = o; v.zero = z; v.len = l; v.sts = s; v.ctls = c; v.ill = il;
    vecs.push_back(v);
  endtask

  initial begin
    int pulses, at, mw_cnt;
    logic [3:0] es, ec;

    add("LW",    6'b100011, 1'b0, 5, 24'h012340, 24'h200090, 1'b0);
    add("SW",    6'b101011, 1'b0, 4, 24'h012500, 24'h200400, 1'b0);
    add("RTYPE", 6'b000000, 1'b0, 4, 24'h016700, 24'h200800, 1'b0);
    add("ADDI",  6'b001000, 1'b0, 4, 24'h019A00, 24'h200800, 1'b0);
    add("BEQ1",  6'b000100, 1'b1, 3, 24'h018000, 24'h202000, 1'b0);
    add("BEQ0",  6'b000100, 1'b0, 3, 24'h018000, 24'h200000, 1'b0);
    add("J",     6'b000010, 1'b0, 3, 24'h01B000, 24'h202000, 1'b0);
    add("ILL3F", 6'b111111, 1'b0, 2, 24'h010000, 24'h200000, 1'b1);
    add("ILL01", 6'b000001, 1'b0, 2, 24'h010000, 24'h200000, 1'b1);

    reset = 1'b0; op = 6'b0; zero = 1'b0; mem_ready = 1'b0;
    #12;
    chk("rst_state", state, 4'd0);
    chk("rst_illegal", illegal_op, 1'b0);
    chk("rst_timeout", mem_timeout, 1'b0);
    chk("rst_pcen", pcen, 1'b0);
    chk("rst_irwrite", irwrite, 1'b0);
    chk("rst_alusrcb", alusrcb, 2'b01);
    chk("rst_memreq", mem_req, 1'b1);
    chk("rst_regwrite", regwrite, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Table: whole instructions with mem_ready tied high.
    foreach (vecs[v]) begin
      op = vecs[v].op; zero = vecs[v].zero; mem_ready = 1'b1;
      for (int i = 0; i < vecs[v].len; i++) begin
        @(negedge clk);
        es = vecs[v].sts[23-4*i -: 4];
        ec = vecs[v].ctls[23-4*i -: 4];
        chk({vecs[v].name, "_state"}, state, es);
        chk({vecs[v].name, "_ctl"}, {regwrite, memwrite, pcen, memtoreg}, ec);
        tick();
      end
      @(negedge clk);
      chk({vecs[v].name, "_end_state"}, state, 4'd0);
      chk({vecs[v].name, "_illegal"}, illegal_op, vecs[v].ill);
      mem_ready = 1'b0;
      tick();
    end
    @(negedge clk);
    chk("illegal_one_cycle", illegal_op, 1'b0);

    // Reset asserted mid-EXECUTE.
    op = 6'b000000; mem_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("mid_exec_state", state, 4'd6);
    reset = 1'b0;
    #1;
    chk("mid_rst_state", state, 4'd0);
    chk("mid_rst_regwrite", regwrite, 1'b0);
    chk("mid_rst_memwrite", memwrite, 1'b0);
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_state", state, 4'd0);
    chk("post_rst_pcen", pcen, 1'b0);
    chk("post_rst_regwrite", regwrite, 1'b0);
    mem_ready = 1'b1;
    #1;
    chk("fetch_irwrite", irwrite, 1'b1);
    chk("fetch_pcen", pcen, 1'b1);
    chk("fetch_alusrcb", alusrcb, 2'b01);
    mem_ready = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();

    // BEQ execute: branch gating follows zero combinationally.
    op = 6'b000100; zero = 1'b1; mem_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("beq_state", state, 4'd8);
    chk("beq_aluop", aluop, 2'b01);
    chk("beq_pcsrc", pcsrc, 2'b01);
    chk("beq_alusrcb", alusrcb, 2'b00);
    chk("beq_alusrca", alusrca, 1'b1);
    chk("beq_pcen_z1", pcen, 1'b1);
    chk("beq_memreq", mem_req, 1'b0);
    zero = 1'b0;
    #1;
    chk("beq_pcen_z0", pcen, 1'b0);
    mem_ready = 1'b0;
    tick();

    // SW with three stall cycles in MEMWR: 7 cycles total, one memwrite.
    op = 6'b101011; mw_cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      mem_ready = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (memwrite) mw_cnt++;
      if (c == 3) chk("sw_memadr", state, 4'd2);
      if (c >= 4 && c <= 6) begin
        chk("sw_stall_state", state, 4'd5);
        chk("sw_stall_memwrite", memwrite, 1'b0);
        chk("sw_stall_memreq", mem_req, 1'b1);
      end
      if (c == 7) begin
        chk("sw_done_state", state, 4'd5);
        chk("sw_memwrite", memwrite, 1'b1);
      end
      tick();
    end
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_end_state", state, 4'd0);
    chk("sw_memwrite_count", mw_cnt, 1);

    // Fetch stall for 20 cycles: a single timeout pulse after the 15th.
    pulses = 0; at = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      @(negedge clk);
      if (mem_timeout) begin
        pulses++;
        at = k;
      end
      chk("tmo_state", state, 4'd0);
    end
    chk("tmo_pulses", pulses, 1);
    chk("tmo_cycle", at, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control state machine for the multicycle MIPS core. Sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. Produces the 2-bit `aluop` that the ALU decoder expands into the 4-bit ALU control. Stalls on a memory-ready handshake so the unified instruction/data memory may take more than one cycle.

## Interface
Parameters:
- `MEM_WAIT_MAX`, 15: maximum stall cycles in a memory state before `mem_timeout` pulses; the state machine keeps waiting after the pulse.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `op` in 6: instruction opcode, `instr[31:26]`, from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `mem_req` out 1: memory access requested; held until `mem_ready`.
- `memwrite`, `irwrite`, `regwrite`, `iord`, `regdst`, `memtoreg`, `alusrca` out 1 each: datapath controls.
- `alusrcb` out 2: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `pcsrc` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluop` out 2: 00 = add, 01 = sub, 10 = use funct.
- `pcen` out 1: PC write enable.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `mem_timeout` out 1: one-cycle pulse when the stall count reaches `MEM_WAIT_MAX`.
- `state` out 4: current state, for debug.

## Operation
- State encoding (4 bits): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11.
- Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
- Transitions:
  - FETCH waits for `mem_ready`, then goes to DECODE.
  - DECODE branches on `op`:
    - LW or SW goes to MEMADR.
    - RTYPE goes to EXECUTE.
    - BEQ goes to BEQEX.
    - ADDI goes to ADDIEX.
    - J goes to JEX.
    - Any other opcode goes to FETCH and pulses `illegal_op`.
  - MEMADR goes to MEMRD for LW and to MEMWR for SW.
  - MEMRD waits for `mem_ready`, then goes to MEMWB. MEMWR waits for `mem_ready`, then goes to FETCH.
  - MEMWB, ALUWB, ADDIWB, BEQEX and JEX go to FETCH. EXECUTE goes to ALUWB. ADDIEX goes to ADDIWB.
- Outputs are a Moore decode of `state`. `pcen` is `pcwrite | (branch & zero)`.
- `irwrite`, `memwrite` and the FETCH `pcwrite` are qualified with `mem_ready`, so each fires exactly once per access.
- `mem_req` is 1 in FETCH, MEMRD and MEMWR, and 0 elsewhere.
- Per-state outputs (unlisted signals are 0):
  - FETCH: `iord` 0, `alusrca` 0, `alusrcb` 01, `aluop` 00, `pcsrc` 00, `irwrite` = `pcwrite` = `mem_ready`.
  - DECODE: `alusrca` 0, `alusrcb` 11, `aluop` 00.
  - MEMADR and ADDIEX: `alusrca` 1, `alusrcb` 10, `aluop` 00.
  - MEMRD: `iord` 1.
  - MEMWB: `regdst` 0, `memtoreg` 1, `regwrite` 1.
  - MEMWR: `iord` 1, `memwrite` = `mem_ready`.
  - EXECUTE: `alusrca` 1, `alusrcb` 00, `aluop` 10.
  - ALUWB: `regdst` 1, `memtoreg` 0, `regwrite` 1.
  - BEQEX: `alusrca` 1, `alusrcb` 00, `aluop` 01, `pcsrc` 01, `branch` 1.
  - ADDIWB: `regdst` 0, `memtoreg` 0, `regwrite` 1.
  - JEX: `pcsrc` 10, `pcwrite` 1.
- Stall counter:
  - 4 bits, saturating at `MEM_WAIT_MAX`.
  - Increments each cycle `mem_req` is 1 and `mem_ready` is 0.
  - Clears on `mem_ready` and on every state change.
  - `mem_timeout` pulses only in the cycle the counter first reaches `MEM_WAIT_MAX`.

## Timing
- Reset value: `state` = FETCH, stall counter 0, `illegal_op` 0, `mem_timeout` 0. All other outputs take their FETCH decode.
- Reset deasserting mid-instruction restarts at FETCH. Any partial instruction is abandoned, and no `regwrite`/`memwrite` occurs during reset.
- Latency with `mem_ready` tied to 1:
  - LW: 5 cycles.
  - SW: 4 cycles.
  - RTYPE and ADDI: 4 cycles.
  - BEQ and J: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_ready` asserted outside a `mem_req` state is ignored.
- `illegal_op` is registered and pulses in the cycle after DECODE, coincident with the return to FETCH.
- Only `state`, the stall counter, `illegal_op` and `mem_timeout` are registered. All other outputs are combinational from `state`, `mem_ready` and `zero`.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - state encoding localparams;
  - opcode constants;
  - `aluop` codes;
  - `alusrcb` and `pcsrc` select codes.
- The ALU decoder also uses the `aluop` codes from this package.
- One sub-module: `mips_ctrl_outdec`, the pure combinational state-to-control decode. The top level holds the next-state logic, state register, stall counter and `pcen` gating.

## Test plan
- Reset low mid-EXECUTE, then release → `state` = 0, `regwrite` 0, `pcen` 0 until `mem_ready`; FETCH with `mem_ready` = 1 gives `irwrite` = 1, `pcen` = 1, `alusrcb` = 01.
- `mem_ready` = 1, `op` = 100011 (LW) → states 0, 1, 2, 3, 4, 0; `regwrite` and `memtoreg` high only in state 4.
- `op` = 000100 (BEQ), `zero` = 1 → BEQEX shows `aluop` 01, `pcsrc` 01, `pcen` 1. Repeat with `zero` = 0 → `pcen` 0.
- SW with `mem_ready` low for 3 cycles in MEMWR → `memwrite` stays 0, then pulses for exactly 1 cycle; SW latency 7 cycles.
- `op` = 111111 → DECODE returns to FETCH; `illegal_op` pulses for 1 cycle; no `regwrite`.
- `mem_ready` held low in FETCH for 20 cycles (`MEM_WAIT_MAX` = 15) → `mem_timeout` pulses once in cycle 15; `state` stays 0.
